// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
// Issues word fetches over a request/grant bus with in-order responses,
// buffers returned words tagged with their PC, and hands them to decode
// over valid/ready. Redirects flush the buffer and discard in-flight
// responses.
// Optional build macro FETCH_MISALIGN_CHK_EN: adds fetch_misaligned and
// halts fetching after a redirect to a non-word-aligned PC.
//
// state | meaning
// FETCH | drop_cnt == 0, responses are pushed into the buffer
// FLUSH | drop_cnt  > 0, responses are wrong-path and discarded
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        nrst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        fetch_misaligned
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic FETCH = 1'b0;
  localparam logic FLUSH = 1'b1;

  logic [31:0]   pc_q;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   fifo_inst [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];

  logic          state;
  logic          halted;
  logic [31:0]   target_pc;
  logic          grant;
  logic          rsp;
  logic          push;
  logic          pop;
  logic [CW:0]   credits_used;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misaligned_q;
  logic redirect_bad;

  assign redirect_bad     = (redirect_pc[1:0] != 2'b00);
  assign halted           = misaligned_q;
  assign fetch_misaligned = misaligned_q;

  // Misalignment flag follows the alignment of the most recent redirect.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      misaligned_q <= 1'b0;
    end else if (redirect) begin
      misaligned_q <= redirect_bad;
    end
  end
`else
  assign halted = 1'b0;
`endif

  // Low address bits of a redirect target are not meaningful for word fetch.
  assign target_pc = redirect_pc & ~32'h3;

  // Dropped (wrong-path) requests still hold a credit until their response returns.
  assign credits_used = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req     = nrst && !halted && (credits_used < (CW+1)'(FIFO_DEPTH));
  assign imem_addr    = pc_q;

  assign grant = imem_req && imem_gnt;
  // A response with nothing outstanding is a bus violation and is ignored.
  assign rsp   = imem_rvalid && (outstanding != '0);
  assign state = (drop_cnt != '0) ? FLUSH : FETCH;
  assign push  = rsp && !redirect && (state == FETCH) && !halted;
  assign pop   = inst_valid && inst_ready && !redirect;

  assign inst_valid = (fifo_count != '0);
  assign inst       = inst_valid ? fifo_inst[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? fifo_pc[rd_ptr]   : '0;

  // PC tracking, credit counter and wrong-path drop counter.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pc_q        <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(grant) - CW'(rsp);
      if (redirect) begin
        pc_q     <= target_pc;
        resp_pc  <= target_pc;
        // Everything still in flight after this cycle is wrong-path,
        // including a request granted in the redirect cycle itself.
        drop_cnt <= outstanding + CW'(grant) - CW'(rsp);
      end else begin
        if (grant) pc_q <= pc_q + 32'd4;
        if (push) resp_pc <= resp_pc + 32'd4;
        if (rsp && (state == FLUSH)) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  // Buffer pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (redirect) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  // Buffer storage; contents are only observed while marked valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]   <= resp_pc;
    end
  end

  // Flag responses that arrive with no request outstanding.
  assert property (@(posedge clk) disable iff (!nrst)
    !(imem_rvalid && (outstanding == '0)));

endmodule
